// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle ARM-subset core:
// FSM states, data-processing opcodes, condition codes and NZCV bit positions.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic cmd_supported(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
           (cmd == CMD_ORR) || (cmd == CMD_MOV) || (cmd == CMD_CMP);
  endfunction

  // CMP is the only supported opcode that updates flags without writing Rd.
  function automatic logic cmd_writes_rd(input logic [3:0] cmd);
    return cmd_supported(cmd) && (cmd != CMD_CMP);
  endfunction

endpackage

// File: rtl/cpu_multicycle_core_if.sv
// Instruction-memory req/ack fetch bus; the core is master, the memory is slave.
interface cpu_multicycle_core_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic [DATA_W-1:0] addr;
  logic              ack;
  logic [31:0]       rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU for ADD/SUB/CMP/AND/ORR/MOV, producing the result and
// the candidate NZCV (C and V pass through for the logical opcodes).
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [3:0]        i_cmd,
  input  logic [3:0]        i_flags,
  output logic [DATA_W-1:0] o_result,
  output logic [3:0]        o_flags
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_diff;
  logic              w_add_v;
  logic              w_sub_v;

  assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff  = i_a - i_b;
  assign w_add_v = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (w_sum[DATA_W-1] != i_a[DATA_W-1]);
  assign w_sub_v = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (w_diff[DATA_W-1] != i_a[DATA_W-1]);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    o_result = '0;
    o_flags  = i_flags;
    case (i_cmd)
      CMD_ADD: begin
        o_result       = w_sum[DATA_W-1:0];
        o_flags[FLAG_C] = w_sum[DATA_W];
        o_flags[FLAG_V] = w_add_v;
      end
      CMD_SUB, CMD_CMP: begin
        o_result       = w_diff;
        o_flags[FLAG_C] = (i_a >= i_b);
        o_flags[FLAG_V] = w_sub_v;
      end
      CMD_AND: o_result = i_a & i_b;
      CMD_ORR: o_result = i_a | i_b;
      CMD_MOV: o_result = i_b;
      default: o_result = '0;
    endcase
    if (cmd_supported(i_cmd)) begin
      o_flags[FLAG_N] = o_result[DATA_W-1];
      o_flags[FLAG_Z] = (o_result == '0);
    end
  end

endmodule

// File: rtl/cpu_multicycle_core.sv
// Multi-cycle FETCH/DECODE/EXEC/WB core for an ARM data-processing/branch subset,
// with req/ack instruction fetch, 16-entry register file and NZCV flags.
module cpu_multicycle_core
  import cpu_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  cpu_multicycle_core_if.master imem,
  input  logic [3:0]            dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  output logic [31:0]           instruction,
  output logic [3:0]            flags,
  output logic                  retire,
  output logic                  illegal
);

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic [3:0]        r_flags;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [DATA_W-1:0] r_result;
  logic [3:0]        r_flags_next;
  logic              r_cond_pass;
  // Entry 15 is never written; R15 reads are redirected to the PC.
  logic [DATA_W-1:0] r_regs [0:15];

  logic [3:0]        w_cond;
  logic              w_is_dp;
  logic              w_is_br;
  logic              w_imm_sel;
  logic [3:0]        w_cmd;
  logic              w_s;
  logic [3:0]        w_rn;
  logic [3:0]        w_rd;
  logic [3:0]        w_rm;
  logic              w_cond_legal;
  logic              w_illegal;
  logic              w_cond_pass;
  logic [DATA_W-1:0] w_pc_plus4;
  logic [DATA_W-1:0] w_pc_plus8;
  logic [DATA_W-1:0] w_rn_val;
  logic [DATA_W-1:0] w_rm_val;
  logic [DATA_W-1:0] w_imm8;
  logic [DATA_W-1:0] w_br_target;
  logic [DATA_W-1:0] w_alu_result;
  logic [3:0]        w_alu_flags;
  logic              w_exec_ok;
  logic              w_do_write;
  logic              w_do_flags;
  logic              w_take_br;
  logic [DATA_W-1:0] w_pc_next;

  assign w_cond    = r_ir[31:28];
  assign w_is_dp   = (r_ir[27:26] == 2'b00);
  assign w_is_br   = (r_ir[27:25] == 3'b101);
  assign w_imm_sel = r_ir[25];
  assign w_cmd     = r_ir[24:21];
  assign w_s       = r_ir[20];
  assign w_rn      = r_ir[19:16];
  assign w_rd      = r_ir[15:12];
  assign w_rm      = r_ir[3:0];

  assign w_cond_legal = (w_cond == COND_AL) || (w_cond == COND_EQ) || (w_cond == COND_NE);
  assign w_illegal    = !w_cond_legal || !(w_is_br || (w_is_dp && cmd_supported(w_cmd)));
  assign w_cond_pass  = (w_cond == COND_AL) ||
                        ((w_cond == COND_EQ) &&  r_flags[FLAG_Z]) ||
                        ((w_cond == COND_NE) && !r_flags[FLAG_Z]);

  assign w_pc_plus4  = r_pc + DATA_W'(4);
  assign w_pc_plus8  = r_pc + DATA_W'(8);
  assign w_rn_val    = (w_rn == 4'd15) ? w_pc_plus8 : r_regs[w_rn];
  assign w_rm_val    = (w_rm == 4'd15) ? w_pc_plus8 : r_regs[w_rm];
  assign w_imm8      = {{(DATA_W-8){1'b0}}, r_ir[7:0]};
  assign w_br_target = w_pc_plus8 + {{(DATA_W-26){r_ir[23]}}, r_ir[23:0], 2'b00};

  cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_a      (r_op_a),
    .i_b      (r_op_b),
    .i_cmd    (w_cmd),
    .i_flags  (r_flags),
    .o_result (w_alu_result),
    .o_flags  (w_alu_flags)
  );

  // Write-back qualifiers; an illegal or condition-failed instruction only advances PC.
  assign w_exec_ok  = r_cond_pass && !w_illegal;
  assign w_do_write = w_exec_ok && w_is_dp && cmd_writes_rd(w_cmd);
  assign w_do_flags = w_exec_ok && w_is_dp && (w_s || (w_cmd == CMD_CMP));
  assign w_take_br  = w_exec_ok && w_is_br;
  assign w_pc_next  = w_take_br                      ? w_br_target :
                      (w_do_write && w_rd == 4'd15)  ? r_result    :
                                                       w_pc_plus4;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH:  if (run && imem.ack) w_state_next = DECODE;
      DECODE: w_state_next = EXEC;
      EXEC:   w_state_next = WB;
      WB:     w_state_next = FETCH;
      default: w_state_next = FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_ir         <= '0;
      r_flags      <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_result     <= '0;
      r_flags_next <= '0;
      r_cond_pass  <= 1'b0;
      // NOTE: the register file is built from flops, so clearing it on reset is legal and required.
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        FETCH: if (run && imem.ack) r_ir <= imem.rdata;
        DECODE: begin
          r_op_a <= w_rn_val;
          r_op_b <= w_imm_sel ? w_imm8 : w_rm_val;
        end
        EXEC: begin
          r_result     <= w_alu_result;
          r_flags_next <= w_alu_flags;
          r_cond_pass  <= w_cond_pass;
        end
        WB: begin
          r_pc <= w_pc_next;
          if (w_do_flags) r_flags <= r_flags_next;
          if (w_do_write && (w_rd != 4'd15)) r_regs[w_rd] <= r_result;
        end
        default: ;
      endcase
    end
  end

  assign imem.req    = (r_state == FETCH) && run && !reset;
  assign imem.addr   = r_pc;
  assign retire      = (r_state == WB) && !reset;
  assign illegal     = retire && w_illegal;
  assign instruction = r_ir;
  assign flags       = r_flags;
  assign dbg_data    = (dbg_addr == 4'd15) ? r_pc : r_regs[dbg_addr];

endmodule

// File: tb/tb_cpu_multicycle_core.sv
// Scoreboard bench: the fetch driver pushes each instruction's expected outcome,
// and an independent monitor pops and checks it whenever retire pulses.
module tb_cpu_multicycle_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [3:0]  dbg_addr;
  logic [3:0]  mon_dbg;
  logic [3:0]  main_dbg;
  logic        main_dbg_en;
  logic [31:0] dbg_data;
  logic [31:0] instruction;
  logic [3:0]  flags;
  logic        retire;
  logic        illegal;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  cpu_multicycle_core_if #(.DATA_W(32)) imem ();

  cpu_multicycle_core #(
    .DATA_W   (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .imem        (imem),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .instruction (instruction),
    .flags       (flags),
    .retire      (retire),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign dbg_addr = main_dbg_en ? main_dbg : mon_dbg;

  typedef struct {
    logic [31:0] instr;
    logic        ill;
    logic [3:0]  rd;
    logic [31:0] rd_val;
    logic [3:0]  flg;
    logic [31:0] pc;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] instr, input logic ill, input logic [3:0] rd,
                              input logic [31:0] rd_val, input logic [3:0] flg,
                              input logic [31:0] pc, input int lat);
    exp_t e;
    e.instr = instr; e.ill = ill; e.rd = rd; e.rd_val = rd_val;
    e.flg = flg; e.pc = pc; e.lat = lat; e.start = 0;
    return e;
  endfunction

  // Called at a falling edge; serves one fetch with 'waits' stall cycles.
  task automatic issue(input logic [31:0] addr, input exp_t e, input int waits, input bit push);
    int n = 0;
    while (!imem.req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!imem.req) begin
      check("req_timeout", 32'(imem.req), 32'd1);
      return;
    end
    check("fetch_addr", imem.addr, addr);
    e.start = cyc;
    for (int w = 0; w < waits; w++) begin
      imem.ack   = 1'b0;
      imem.rdata = 32'hDEADBEEF;
      @(negedge clk);
      check("wait_req", 32'(imem.req), 32'd1);
      check("wait_addr", imem.addr, addr);
    end
    imem.ack   = 1'b1;
    imem.rdata = e.instr;
    if (push) sb.push_back(e);
    @(negedge clk);
    imem.ack   = 1'b0;
    imem.rdata = 32'h0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: retire triggers comparison against the oldest expected entry.
  initial begin
    exp_t e;
    mon_dbg = 4'd0;
    forever begin
      @(negedge clk);
      if (retire) begin
        if (sb.size() == 0) begin
          check("unexpected_retire", 32'(retire), 32'd0);
        end else begin
          e = sb.pop_front();
          check("illegal", 32'(illegal), 32'(e.ill));
          check("ir", instruction, e.instr);
          check("latency", 32'(cyc - e.start), 32'(e.lat));
          @(posedge clk);
          #1 mon_dbg = e.rd;
          #1 check("rd_value", dbg_data, e.rd_val);
          check("flags", 32'(flags), 32'(e.flg));
          mon_dbg = 4'd15;
          #1 check("pc", dbg_data, e.pc);
          check("imem_addr", imem.addr, e.pc);
        end
      end
    end
  end

  exp_t prog[$];
  int   prog_waits[$];
  logic [31:0] prog_addr[$];

  initial begin
    reset       = 1'b1;
    run         = 1'b0;
    main_dbg_en = 1'b1;
    main_dbg    = 4'd1;
    imem.ack    = 1'b0;
    imem.rdata  = 32'h0;

    // addr, expectation(instr, illegal, rd, rd value, NZCV, next PC, latency), waits
    prog_addr.push_back(32'h00); prog.push_back(mk(32'hE2801005, 0, 4'd1,  32'h5,        4'h0, 32'h04, 3)); prog_waits.push_back(0);
    prog_addr.push_back(32'h04); prog.push_back(mk(32'hE2512005, 0, 4'd2,  32'h0,        4'h6, 32'h08, 3)); prog_waits.push_back(0);
    prog_addr.push_back(32'h08); prog.push_back(mk(32'h0A000001, 0, 4'd2,  32'h0,        4'h6, 32'h14, 3)); prog_waits.push_back(0);
    prog_addr.push_back(32'h14); prog.push_back(mk(32'hE1813002, 0, 4'd3,  32'h5,        4'h6, 32'h18, 3)); prog_waits.push_back(0);
    prog_addr.push_back(32'h18); prog.push_back(mk(32'hE2504001, 0, 4'd4,  32'hFFFFFFFF, 4'h8, 32'h1C, 3)); prog_waits.push_back(0);
    prog_addr.push_back(32'h1C); prog.push_back(mk(32'h0A000001, 0, 4'd4,  32'hFFFFFFFF, 4'h8, 32'h20, 3)); prog_waits.push_back(0);
    prog_addr.push_back(32'h20); prog.push_back(mk(32'hE3A0502A, 0, 4'd5,  32'h2A,       4'h8, 32'h24, 6)); prog_waits.push_back(3);
    prog_addr.push_back(32'h24); prog.push_back(mk(32'hF2801005, 1, 4'd1,  32'h5,        4'h8, 32'h28, 3)); prog_waits.push_back(0);
    prog_addr.push_back(32'h28); prog.push_back(mk(32'hE2946001, 0, 4'd6,  32'h0,        4'h6, 32'h2C, 3)); prog_waits.push_back(0);
    prog_addr.push_back(32'h2C); prog.push_back(mk(32'hE3510007, 0, 4'd0,  32'h0,        4'h8, 32'h30, 3)); prog_waits.push_back(0);
    prog_addr.push_back(32'h30); prog.push_back(mk(32'hE205800F, 0, 4'd8,  32'h0A,       4'h8, 32'h34, 3)); prog_waits.push_back(0);
    prog_addr.push_back(32'h34); prog.push_back(mk(32'hE3A0F040, 0, 4'd15, 32'h40,       4'h8, 32'h40, 3)); prog_waits.push_back(0);
    prog_addr.push_back(32'h40); prog.push_back(mk(32'h1A000000, 0, 4'd0,  32'h0,        4'h8, 32'h48, 3)); prog_waits.push_back(0);
    prog_addr.push_back(32'h48); prog.push_back(mk(32'hE0949004, 0, 4'd9,  32'hFFFFFFFE, 4'hA, 32'h4C, 3)); prog_waits.push_back(0);
    prog_addr.push_back(32'h4C); prog.push_back(mk(32'hE24FA04C, 0, 4'd10, 32'h8,        4'hA, 32'h50, 3)); prog_waits.push_back(1);

    prog[14].lat = 4;

    repeat (2) @(negedge clk);
    run = 1'b1;
    #1;
    check("rst_req", 32'(imem.req), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_ir", instruction, 32'd0);
    check("rst_pc", imem.addr, 32'd0);
    check("rst_r1", dbg_data, 32'd0);
    main_dbg_en = 1'b0;

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < prog.size(); i++) issue(prog_addr[i], prog[i], prog_waits[i], 1'b1);
    wait_drain();

    // Hold in FETCH with run low: no request, PC frozen.
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("run0_req", 32'(imem.req), 32'd0);
      check("run0_pc", imem.addr, 32'h50);
      @(negedge clk);
    end
    run = 1'b1;

    // Reset while an ADD R1,R0,#7 is in EXEC: it must never retire or write R1.
    issue(32'h50, mk(32'hE2801007, 0, 4'd1, 32'h7, 4'h0, 32'h54, 3), 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_exec_retire", 32'(retire), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run   = 1'b0;
    main_dbg_en = 1'b1;
    #1;
    check("post_rst_pc", imem.addr, 32'h0);
    check("post_rst_flags", 32'(flags), 32'd0);
    check("post_rst_ir", instruction, 32'd0);
    check("post_rst_req", 32'(imem.req), 32'd0);
    main_dbg = 4'd1;  #1 check("post_rst_r1", dbg_data, 32'd0);
    main_dbg = 4'd5;  #1 check("post_rst_r5", dbg_data, 32'd0);
    main_dbg = 4'd10; #1 check("post_rst_r10", dbg_data, 32'd0);
    main_dbg_en = 1'b0;
    @(negedge clk);
    run = 1'b1;
    issue(32'h00, mk(32'hE2801005, 0, 4'd1, 32'h5, 4'h0, 32'h04, 3), 0, 1'b1);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
